// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine.
//   DATA_W_DEF / ADDR_W_DEF : default register width and index width
//   state_t                 : dump FSM state encoding
package regfile_dump_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Walks a range of architectural registers through the RegisterFile read port
// and streams each (index, value) pair out over a valid/ready interface.
//   clk, rst        : clock, synchronous active-high reset
//   start/first/last: dump request, inclusive index range, sampled in IDLE
//   rn, data1       : RegisterFile read address / combinational read data
//   out_valid/ready : beat handshake; out_data/out_idx carry the beat
//   busy, done      : activity flag, one-cycle completion pulse
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] rn,
  input  logic [DATA_W-1:0] data1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_q;

  // The read address is the walking index itself, in every state.
  assign rn = idx;

  // out_valid, busy and done are registered alongside the state so they
  // change exactly on the state transitions that define them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      last_q    <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (first <= last) begin
              idx    <= first;
              last_q <= last;
              state  <= ST_READ;
            end else begin
              // Empty range: no beats, straight to completion.
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          out_data  <= data1;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Compare before incrementing so the index never wraps past 31.
            if (idx == last_q) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
